fw_alert_handler: RTL and testbench
===================================

Name: fw_alert_handler

Overview:
- Consumer at the far end of top_firewall's alert path; takes alert/block indications plus the offending transaction (addr, data, wr/rd).
- Logs each violation into a small readable FIFO.
- Runs an escalation state machine NORMAL -> WARN -> LOCKDOWN with a quiet-period cooldown.
- Drives lockdown and the 2-bit status level that board LEDs and the bus master consume.

Parameters:
- LOG_DEPTH, 8, FIFO entries; power of two, >= 2.
- WARN_THRESH, 2, violation count that enters WARN.
- LOCK_THRESH, 4, violation count that enters LOCKDOWN; must exceed WARN_THRESH.
- COOLDOWN_CYCLES, 20, consecutive event-free cycles that de-escalate WARN and clear the count.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- alert_in  in  1  firewall alert_out.
- block_in  in  1  firewall firewall_block.
- addr_in  in  16  transaction address, same cycle as the alert.
- data_in  in  32  transaction data, same cycle as the alert.
- wr_in  in  1  transaction was a write (0 = read).
- clr_lock  in  1  one-cycle software clear of lockdown and overflow.
- log_pop  in  1  consume head log entry.
- log_valid  out  1  FIFO non-empty.
- log_addr  out  16  head entry address.
- log_data  out  32  head entry data.
- log_cause  out  2  head entry: bit1 = block, bit0 = alert.
- log_wr  out  1  head entry write flag.
- log_count  out  $clog2(LOG_DEPTH+1)  entries held.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- level  out  2  00 NORMAL, 01 WARN, 10 LOCKDOWN.
- lockdown  out  1  equals (level == LOCKDOWN).

Behaviour:
- Reset values: all outputs 0, FIFO empty, viol_cnt = 0, cooldown = 0, state NORMAL. Reset is asynchronous, so reset mid-operation discards all entries and counts immediately.
- Event definition: event = alert_in | block_in, sampled each rising clk edge. Every asserted cycle is one event, including held-high cycles.
- Logging: an event pushes {addr_in, data_in, wr_in, cause} in the same edge. FIFO is first-word-fall-through, so the head is visible on the cycle after the push.
- Pop: log_pop while log_valid advances the head. log_pop while empty is ignored.
- Push while full: entry dropped, overflow set, unless a pop occurs in the same cycle; push and pop together when full both succeed and count is unchanged.
- Push and pop together when empty: the push occurs and the pop is ignored.
- Pointers wrap modulo LOG_DEPTH.
- viol_cnt: saturating counter, incremented per event. The cooldown counter reloads to COOLDOWN_CYCLES on each event and decrements otherwise.
- NORMAL -> WARN on the edge where viol_cnt+1 >= WARN_THRESH.
- WARN -> LOCKDOWN on the edge where viol_cnt+1 >= LOCK_THRESH.
- A single event can jump straight to LOCKDOWN if the thresholds allow it.
- Cooldown: when the counter reaches 0 in NORMAL or WARN, viol_cnt clears and the state returns to NORMAL.
- LOCKDOWN is sticky; it ignores cooldown and is left only via clr_lock.
- clr_lock: state NORMAL, viol_cnt = 0, cooldown = 0, overflow = 0 on the next edge. The FIFO contents are kept.
- clr_lock and an event in the same cycle: the clear wins for FSM and counters, but the event is still logged.
- Latency: level and lockdown are registered, 1 cycle after the triggering event edge. No combinational path from inputs to outputs.

Optional Feature:
- Macro FW_LOG_TIMESTAMP_EN.
- Defined: a 16-bit free-running cycle counter (reset 0, wraps at 0xFFFF) is stored with each entry and exposed on an extra output log_ts[15:0].
- Not defined: no counter, no log_ts port, entry width unchanged otherwise.

Decomposition:
- Package fw_pkg holds:
  - level encodings LVL_NORMAL, LVL_WARN, LVL_LOCK;
  - cause bit positions;
  - the entry-width localparam, which depends on FW_LOG_TIMESTAMP_EN.
- Sub-module fw_log_fifo: generic FWFT FIFO with push, pop, full, empty, count, and parameters WIDTH and DEPTH.
- The FSM and counters stay in fw_alert_handler.

Test Plan:
- Reset, then a single alert_in pulse with addr 0x1234, data 0xDEADBEEF, wr = 1 -> log_valid = 1 next cycle, head matches, cause = 01, log_wr = 1, level stays 00.
- Two events 1 cycle apart, then 20 idle cycles -> level = 01 after the 2nd event, back to 00 exactly 20 cycles after the last event.
- Four events with block_in = 1 (data 0xAAAA5555) -> level 01 then 10, lockdown = 1. Then 400 ns idle -> still 10. Then clr_lock pulse -> level 00 next cycle.
- 9 events with no pops at LOG_DEPTH = 8 -> log_count = 8, overflow = 1, the 9th entry is absent. Pop all 8 in order; log_valid drops after the 8th pop.
- FIFO full, then push and pop in the same cycle -> count stays 8, overflow stays 0, new entry at tail. Pop while empty -> no change.
- clr_lock and an event in the same cycle during LOCKDOWN -> level 00, viol_cnt 0, entry logged. With FW_LOG_TIMESTAMP_EN, log_ts equals the cycle index of the event.

Source files
------------

// File: rtl/fw_pkg.sv
// fw_pkg: shared level encodings, cause bit positions and log entry layout
// for the firewall alert handler.
// Build option: FW_LOG_TIMESTAMP_EN adds a 16-bit cycle timestamp to each entry.
package fw_pkg;

    typedef enum logic [1:0] {
        LVL_NORMAL = 2'b00,
        LVL_WARN   = 2'b01,
        LVL_LOCK   = 2'b10
    } level_e;

    localparam int CAUSE_ALERT = 0;
    localparam int CAUSE_BLOCK = 1;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int TS_W   = 16;

`ifdef FW_LOG_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + ADDR_W + DATA_W + 1 + 2;
`else
    localparam int ENTRY_W = ADDR_W + DATA_W + 1 + 2;
`endif

    typedef struct packed {
`ifdef FW_LOG_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr;
        logic [1:0]        cause;
    } log_entry_t;

endpackage

// File: rtl/fw_log_fifo.sv
// fw_log_fifo: generic first-word-fall-through FIFO. The head entry is on
// rdata whenever empty is low. A push into a full FIFO is accepted only when
// a pop happens in the same cycle; a pop while empty is ignored.
module fw_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage write; left unreset since occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fw_alert_handler.sv
// fw_alert_handler: logs firewall violations into a FWFT FIFO and runs the
// NORMAL -> WARN -> LOCKDOWN escalation with a quiet-period cooldown.
// Build option: FW_LOG_TIMESTAMP_EN stores a free-running 16-bit cycle count
// with each entry and exposes it on log_ts.
module fw_alert_handler
    import fw_pkg::*;
#(
    parameter int LOG_DEPTH       = 8,
    parameter int WARN_THRESH     = 2,
    parameter int LOCK_THRESH     = 4,
    parameter int COOLDOWN_CYCLES = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alert_in,
    input  logic                           block_in,
    input  logic [15:0]                    addr_in,
    input  logic [31:0]                    data_in,
    input  logic                           wr_in,
    input  logic                           clr_lock,
    input  logic                           log_pop,
    output logic                           log_valid,
    output logic [15:0]                    log_addr,
    output logic [31:0]                    log_data,
    output logic [1:0]                     log_cause,
    output logic                           log_wr,
    output logic [$clog2(LOG_DEPTH+1)-1:0] log_count,
    output logic                           overflow,
    output logic [1:0]                     level,
    output logic                           lockdown
`ifdef FW_LOG_TIMESTAMP_EN
    ,
    output logic [15:0]                    log_ts
`endif
);
    localparam int CNT_W = $clog2(LOCK_THRESH + 1);
    localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);

    level_e           state;
    logic [CNT_W-1:0] viol_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CD_W-1:0]  cd_cnt;
    logic             evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    log_entry_t       wr_entry;
    log_entry_t       head;
    logic [ENTRY_W-1:0] head_bits;

    assign evt     = alert_in | block_in;
    // Full means non-empty, so any pop this cycle frees a slot for the push.
    assign drop    = evt && fifo_full && !log_pop;
    assign cnt_inc = (viol_cnt == '1) ? viol_cnt : viol_cnt + 1'b1;

`ifdef FW_LOG_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    // Free-running cycle stamp, wraps at 0xFFFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_cnt <= '0;
        else      ts_cnt <= ts_cnt + 1'b1;
    end
`endif

    // Assemble the log entry from the transaction presented with the alert.
    always_comb begin
        wr_entry                    = '0;
        wr_entry.addr               = addr_in;
        wr_entry.data               = data_in;
        wr_entry.wr                 = wr_in;
        wr_entry.cause[CAUSE_ALERT] = alert_in;
        wr_entry.cause[CAUSE_BLOCK] = block_in;
`ifdef FW_LOG_TIMESTAMP_EN
        wr_entry.ts                 = ts_cnt;
`endif
    end

    fw_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .rst   (rst),
        .push  (evt),
        .pop   (log_pop),
        .wdata (wr_entry),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (log_count)
    );

    assign head      = log_entry_t'(head_bits);
    assign log_valid = !fifo_empty;
    assign level     = state;

    // Present the head entry, forced to zero while the log is empty.
    always_comb begin
        log_addr  = '0;
        log_data  = '0;
        log_cause = '0;
        log_wr    = 1'b0;
`ifdef FW_LOG_TIMESTAMP_EN
        log_ts    = '0;
`endif
        if (!fifo_empty) begin
            log_addr  = head.addr;
            log_data  = head.data;
            log_cause = head.cause;
            log_wr    = head.wr;
`ifdef FW_LOG_TIMESTAMP_EN
            log_ts    = head.ts;
`endif
        end
    end

    // Escalation FSM with violation count, cooldown and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LVL_NORMAL;
            lockdown <= 1'b0;
            viol_cnt <= '0;
            cd_cnt   <= '0;
            overflow <= 1'b0;
        end else if (clr_lock) begin
            // Clear wins over a same-cycle event; the FIFO still logs it.
            state    <= LVL_NORMAL;
            lockdown <= 1'b0;
            viol_cnt <= '0;
            cd_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (evt) begin
                viol_cnt <= cnt_inc;
                cd_cnt   <= CD_W'(COOLDOWN_CYCLES);
                if (state != LVL_LOCK) begin
                    if (int'(cnt_inc) >= LOCK_THRESH) begin
                        state    <= LVL_LOCK;
                        lockdown <= 1'b1;
                    end else if (int'(cnt_inc) >= WARN_THRESH) begin
                        state    <= LVL_WARN;
                    end
                end
            end else if (cd_cnt != '0) begin
                cd_cnt <= cd_cnt - 1'b1;
                // Lockdown is sticky; only the quiet period outside it de-escalates.
                if (cd_cnt == CD_W'(1) && state != LVL_LOCK) begin
                    viol_cnt <= '0;
                    state    <= LVL_NORMAL;
                end
            end
        end
    end

endmodule

// File: tb/tb_fw_alert_handler.sv
// tb_fw_alert_handler: directed plus randomized stimulus against a queue-based
// reference model; a negedge monitor compares every DUT output to the model.
module tb_fw_alert_handler;
    localparam int DEPTH = 8;
    localparam int WARN  = 2;
    localparam int LOCK  = 4;
    localparam int COOL  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alert_in = 1'b0, block_in = 1'b0, wr_in = 1'b0;
    logic        clr_lock = 1'b0, log_pop = 1'b0;
    logic [15:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic        log_valid, log_wr, overflow, lockdown;
    logic [15:0] log_addr;
    logic [31:0] log_data;
    logic [1:0]  log_cause, level;
    logic [$clog2(DEPTH+1)-1:0] log_count;
`ifdef FW_LOG_TIMESTAMP_EN
    logic [15:0] log_ts;
`endif

    fw_alert_handler #(
        .LOG_DEPTH(DEPTH), .WARN_THRESH(WARN), .LOCK_THRESH(LOCK), .COOLDOWN_CYCLES(COOL)
    ) dut (
        .clk(clk), .rst(rst), .alert_in(alert_in), .block_in(block_in),
        .addr_in(addr_in), .data_in(data_in), .wr_in(wr_in),
        .clr_lock(clr_lock), .log_pop(log_pop),
        .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
        .log_cause(log_cause), .log_wr(log_wr), .log_count(log_count),
        .overflow(overflow), .level(level), .lockdown(lockdown)
`ifdef FW_LOG_TIMESTAMP_EN
        , .log_ts(log_ts)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [15:0] ts;
        logic [15:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [1:0]  cause;
    } ent_t;

    // Reference model state: log contents as a queue, escalation as plain counts.
    ent_t exp_q[$];
    int   m_lvl, m_vc, m_quiet, m_cyc;
    bit   m_ovf;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk or negedge rst) begin : model
        bit   ev, pop_ok, push_ok;
        ent_t e;
        if (!rst) begin
            exp_q.delete();
            m_lvl = 0; m_vc = 0; m_quiet = COOL + 1; m_cyc = 0; m_ovf = 1'b0;
        end else begin
            ev      = alert_in | block_in;
            pop_ok  = log_pop && (exp_q.size() > 0);
            push_ok = ev && ((exp_q.size() < DEPTH) || pop_ok);
            if (pop_ok) void'(exp_q.pop_front());
            if (push_ok) begin
                e.ts = 16'(m_cyc); e.addr = addr_in; e.data = data_in;
                e.wr = wr_in; e.cause = {block_in, alert_in};
                exp_q.push_back(e);
            end
            if (clr_lock) begin
                m_lvl = 0; m_vc = 0; m_quiet = COOL + 1; m_ovf = 1'b0;
            end else begin
                if (ev && !push_ok) m_ovf = 1'b1;
                if (ev) begin
                    m_vc    = m_vc + 1;
                    m_quiet = 0;
                    if (m_lvl != 2) begin
                        if (m_vc >= LOCK)      m_lvl = 2;
                        else if (m_vc >= WARN) m_lvl = 1;
                    end
                end else if (m_quiet < COOL) begin
                    m_quiet = m_quiet + 1;
                    if (m_quiet == COOL && m_lvl != 2) begin
                        m_vc = 0; m_lvl = 0;
                    end
                end
            end
            m_cyc = (m_cyc + 1) % 65536;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs to the model away from the active edge.
    always @(negedge clk) begin
        chk("log_valid", 64'(log_valid), 64'(exp_q.size() > 0));
        chk("log_count", 64'(log_count), 64'(exp_q.size()));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("level",     64'(level),     64'(m_lvl));
        chk("lockdown",  64'(lockdown),  64'(m_lvl == 2));
        if (exp_q.size() > 0) begin
            chk("log_addr",  64'(log_addr),  64'(exp_q[0].addr));
            chk("log_data",  64'(log_data),  64'(exp_q[0].data));
            chk("log_cause", 64'(log_cause), 64'(exp_q[0].cause));
            chk("log_wr",    64'(log_wr),    64'(exp_q[0].wr));
`ifdef FW_LOG_TIMESTAMP_EN
            chk("log_ts",    64'(log_ts),    64'(exp_q[0].ts));
`endif
        end
    end

    task automatic step(input bit a, input bit b, input logic [15:0] ad, input logic [31:0] d,
                        input bit w, input bit clr, input bit pop);
        alert_in = a; block_in = b; addr_in = ad; data_in = d; wr_in = w;
        clr_lock = clr; log_pop = pop;
        @(posedge clk);
        #1;
        alert_in = 1'b0; block_in = 1'b0; clr_lock = 1'b0; log_pop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pops(input int n);
        repeat (n) step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pct, len;
        #35 rst = 1'b1;
        @(posedge clk); #1;

        // Single alert, then drain it.
        step(1'b1, 1'b0, 16'h1234, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        idle(2);
        pops(1);
        idle(25);

        // Two events one cycle apart, then the quiet period.
        step(1'b1, 1'b0, 16'h0010, 32'h1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 16'h0020, 32'h2, 1'b1, 1'b0, 1'b0);
        idle(22);

        // Four block events escalate to lockdown, which survives 400 ns idle.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 16'(16'h0100 + i), 32'hAAAA5555, 1'b1, 1'b0, 1'b0);
        idle(20);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(2);
        pops(8);

        // Nine events without pops: ninth dropped, overflow set.
        for (int i = 0; i < 9; i++)
            step(1'b1, 1'b0, 16'(16'h0200 + i), 32'(i), 1'b0, 1'b0, 1'b0);
        idle(2);
        // Clear overflow, then push and pop together while full.
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0300, 32'hC0FFEE, 1'b1, 1'b0, 1'b1);
        idle(1);
        pops(10);

        // Clear and event in the same cycle while locked.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 16'(16'h0400 + i), 32'h5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0500, 32'h12345678, 1'b1, 1'b1, 1'b0);
        idle(3);
        pops(6);

        // Asynchronous reset in the middle of activity.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 16'(16'h0600 + i), 32'h7, 1'b1, 1'b0, 1'b0);
        #5 rst = 1'b0;
        #20 rst = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Randomized segments with varying event density.
        for (int s = 0; s < 120; s++) begin
            case ($urandom_range(0, 2))
                0:       pct = 0;
                1:       pct = 8;
                default: pct = 45;
            endcase
            len = $urandom_range(5, 35);
            for (int c = 0; c < len; c++) begin
                bit ev, a, b;
                ev = ($urandom_range(0, 99) < pct);
                a  = ev && ($urandom_range(0, 2) != 0);
                b  = ev && (!a || ($urandom_range(0, 1) == 1));
                step(a, b, 16'($urandom), $urandom, 1'($urandom),
                     ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30));
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
